// File: rtl/decode_unit.sv
// Decode stage: splits a 16-bit instruction into fields, reads operands from an 8x16 register file.
// Optional macro DECODE_WB_PORT_EN adds a writeback port with write-through bypass.
module decode_unit #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              is_branch_taken,
    input  logic [15:0]       instr,
`ifdef DECODE_WB_PORT_EN
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic [4:0]        imm,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic              imm_flag,
    output logic [2:0]        rd
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [4:0]        imm_q,    imm_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [DATA_W-1:0] bt_q,     bt_d;
    logic [DATA_W-1:0] op1_q,    op1_d;
    logic [DATA_W-1:0] op2_q,    op2_d;
    logic              flag_q,   flag_d;
    logic [2:0]        rd_q,     rd_d;

    logic [3:0] f_opcode;
    logic       f_i;
    logic [2:0] f_rd, f_rs1, f_rs2;
    logic [4:0] f_imm5;

    assign f_opcode = instr[15:12];
    assign f_i      = instr[11];
    assign f_rd     = instr[10:8];
    assign f_rs1    = instr[7:5];
    assign f_rs2    = instr[4:2];
    assign f_imm5   = instr[4:0];

    // Register file; writeback (when present) is independent of stall/flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
`ifdef DECODE_WB_PORT_EN
        end else if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
`endif
        end
    end

    logic [DATA_W-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = regs_q[f_rs1];
        rs2_val = regs_q[f_rs2];
`ifdef DECODE_WB_PORT_EN
        // Same-cycle write wins so the operand is never stale.
        if (wb_en && (wb_addr == f_rs1)) rs1_val = wb_data;
        if (wb_en && (wb_addr == f_rs2)) rs2_val = wb_data;
`endif
    end

    always_comb begin
        imm_d    = '0;
        opcode_d = '0;
        bt_d     = '0;
        op1_d    = '0;
        op2_d    = '0;
        flag_d   = 1'b0;
        rd_d     = '0;
        if (is_branch_taken) begin
            // bubble: defaults already zero
        end else if (stall) begin
            imm_d    = imm_q;
            opcode_d = opcode_q;
            bt_d     = bt_q;
            op1_d    = op1_q;
            op2_d    = op2_q;
            flag_d   = flag_q;
            rd_d     = rd_q;
        end else if (f_opcode == 4'h0) begin
            // NOP: everything stays zero
        end else if (f_opcode == 4'hC || f_opcode == 4'hD) begin
            opcode_d = f_opcode;
            bt_d     = {{(DATA_W-12){instr[11]}}, instr[11:0]};
        end else begin
            opcode_d = f_opcode;
            rd_d     = f_rd;
            op1_d    = rs1_val;
            if (f_i) begin
                flag_d = 1'b1;
                imm_d  = f_imm5;
                op2_d  = {{(DATA_W-5){f_imm5[4]}}, f_imm5};
            end else begin
                op2_d  = rs2_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imm_q    <= '0;
            opcode_q <= '0;
            bt_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            flag_q   <= 1'b0;
            rd_q     <= '0;
        end else begin
            imm_q    <= imm_d;
            opcode_q <= opcode_d;
            bt_q     <= bt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            flag_q   <= flag_d;
            rd_q     <= rd_d;
        end
    end

    assign imm           = imm_q;
    assign opcode        = opcode_q;
    assign branch_target = bt_q;
    assign op1           = op1_q;
    assign op2           = op2_q;
    assign imm_flag      = flag_q;
    assign rd            = rd_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: hand-computed vectors, immediate assertions, one line per step.
module tb_decode_unit;

    logic        clk = 1'b0;
    logic        reset, stall, is_branch_taken;
    logic [15:0] instr;
    logic [4:0]  imm;
    logic [3:0]  opcode;
    logic [15:0] branch_target, op1, op2;
    logic        imm_flag;
    logic [2:0]  rd;
`ifdef DECODE_WB_PORT_EN
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .is_branch_taken (is_branch_taken),
        .instr           (instr),
`ifdef DECODE_WB_PORT_EN
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
`endif
        .imm             (imm),
        .opcode          (opcode),
        .branch_target   (branch_target),
        .op1             (op1),
        .op2             (op2),
        .imm_flag        (imm_flag),
        .rd              (rd)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [3:0] e_op, input logic [4:0] e_imm,
                              input logic e_flag, input logic [2:0] e_rd, input logic [15:0] e_op1,
                              input logic [15:0] e_op2, input logic [15:0] e_bt);
        chk({tag, ".opcode"},        16'(opcode),   16'(e_op));
        chk({tag, ".imm"},           16'(imm),      16'(e_imm));
        chk({tag, ".imm_flag"},      16'(imm_flag), 16'(e_flag));
        chk({tag, ".rd"},            16'(rd),       16'(e_rd));
        chk({tag, ".op1"},           op1,           e_op1);
        chk({tag, ".op2"},           op2,           e_op2);
        chk({tag, ".branch_target"}, branch_target, e_bt);
        $display("step %-10s instr=%h op=%h imm=%h flag=%b rd=%0d op1=%h op2=%h bt=%h",
                 tag, instr, opcode, imm, imm_flag, rd, op1, op2, branch_target);
    endtask

    initial begin
        logic [15:0] r2_exp;
        reset = 1'b1; stall = 1'b0; is_branch_taken = 1'b0; instr = 16'hFCB7;
`ifdef DECODE_WB_PORT_EN
        wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
        r2_exp = 16'hABCD;
`else
        r2_exp = 16'h0002;
`endif
        step();
        expect_all("reset", 4'h0, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        reset = 1'b0; instr = 16'h0000;
        step();
        expect_all("nop0", 4'h0, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        instr = 16'hFCB7;
        step();
        expect_all("imm_FCB7", 4'hF, 5'h17, 1'b1, 3'd4, 16'h0005, 16'hFFF7, 16'h0000);

        instr = 16'h2294;
        step();
        expect_all("reg_2294", 4'h2, 5'h00, 1'b0, 3'd2, 16'h0004, 16'h0005, 16'h0000);

        // Stall holds non-zero outputs and ignores the new instr
        stall = 1'b1; instr = 16'hDE60;
        step();
        expect_all("stall_hold", 4'h2, 5'h00, 1'b0, 3'd2, 16'h0004, 16'h0005, 16'h0000);

        stall = 1'b0;
        step();
        expect_all("br_DE60", 4'hD, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'hFE60);

        is_branch_taken = 1'b1;
        step();
        expect_all("flush", 4'h0, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        is_branch_taken = 1'b0; stall = 1'b1; instr = 16'h3A51;
`ifdef DECODE_WB_PORT_EN
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hABCD;
`endif
        step();
        expect_all("stall_zero", 4'h0, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
`ifdef DECODE_WB_PORT_EN
        wb_en = 1'b0;
`endif

        stall = 1'b0;
        step();
        expect_all("imm_3A51", 4'h3, 5'h11, 1'b1, 3'd2, r2_exp, 16'hFFF1, 16'h0000);

        instr = 16'hC123;
        step();
        expect_all("br_C123", 4'hC, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0123);

        instr = 16'h0FFF;
        step();
        expect_all("nop_junk", 4'h0, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        // I=0 with rs1=7, rs2=6, low bits set to confirm they are ignored
        instr = 16'h57FB;
        step();
        expect_all("reg_57FB", 4'h5, 5'h00, 1'b0, 3'd7, 16'h0007, 16'h0006, 16'h0000);

        // Flush beats stall
        stall = 1'b1; is_branch_taken = 1'b1; instr = 16'hFCB7;
        step();
        expect_all("flush_stall", 4'h0, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        stall = 1'b0; is_branch_taken = 1'b0;
        step();
        expect_all("imm_FCB7b", 4'hF, 5'h17, 1'b1, 3'd4, 16'h0005, 16'hFFF7, 16'h0000);

        // Reset during stall clears everything, including the register file
        stall = 1'b1; reset = 1'b1;
        step();
        expect_all("rst_stall", 4'h0, 5'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000);

        reset = 1'b0; stall = 1'b0; instr = 16'h3A51;
        step();
        expect_all("post_rst", 4'h3, 5'h11, 1'b1, 3'd2, 16'h0002, 16'hFFF1, 16'h0000);

`ifdef DECODE_WB_PORT_EN
        // Write-through bypass: same-cycle write to rs2 visible in op2
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234; instr = 16'h2294;
        step();
        expect_all("wb_bypass", 4'h2, 5'h00, 1'b0, 3'd2, 16'h0004, 16'h1234, 16'h0000);
        wb_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
